batch_avg_unit: RTL and testbench
=================================

// Module: batch_avg_unit
// PURPOSE
//   Parametrised streaming averager: accumulates a run-time number of signed samples,
//   then divides the sum by that count with an iterative (1 bit/cycle) divider.
//   Replaces fixed 8-input add chains followed by a combinational DIV; sits between a
//   sample producer and a consumer, with valid/ready handshakes on both sides.
// PARAMETERS
//   DATAW   16  sample and average width, signed two's complement
//   MAX_N   8   maximum samples per batch; cfg_num above MAX_N is clamped to MAX_N
//   COUNTW  $clog2(MAX_N+1)  width of cfg_num (derived, do not override)
//   ACCW    DATAW+$clog2(MAX_N)  accumulator width (derived, do not override)
// PORTS
//   clk       in   1       clock, rising edge
//   rst       in   1       synchronous reset, active high
//   start     in   1       begin a batch; honoured only in IDLE
//   cfg_num   in   COUNTW  samples in the batch (unsigned); sampled when start is honoured
//   in_valid  in   1       sample valid
//   in_ready  out  1       sample accepted when in_valid && in_ready
//   in_data   in   DATAW   signed sample
//   out_valid out  1       result valid; held until accepted
//   out_ready in   1       consumer accepts when out_valid && out_ready
//   avg       out  DATAW   signed sum/num, truncated toward zero
//   sum       out  ACCW    signed sum of the batch
//   div_zero  out  1       batch started with cfg_num==0
//   busy      out  1       high in any state except IDLE
// BEHAVIOUR
//   Reset: state=IDLE; in_ready, out_valid, div_zero, busy = 0; avg, sum = 0; accumulator cleared.
//   rst has priority over every other input in every state; a batch in progress is dropped.
//   States: IDLE -> ACCUM -> DIVIDE -> DONE -> IDLE.
//   IDLE: start=1: latch n=min(cfg_num,MAX_N), clear accumulator.
//     n==0 -> DONE next cycle with avg=0, sum=0, div_zero=1. Otherwise -> ACCUM.
//   ACCUM: in_ready=1. Each handshake adds sign-extended in_data to the ACCW accumulator
//     and decrements the remaining count; the n-th handshake -> DIVIDE next cycle.
//     Gaps in in_valid are allowed; no sample is accepted outside ACCUM.
//   DIVIDE: in_ready=0. Restoring division of |sum| by n, exactly ACCW cycles, then DONE.
//     Quotient sign = sign of sum; remainder discarded (truncate toward zero).
//     |avg| <= max|sample|, so the quotient always fits DATAW; no saturation logic.
//   DONE: out_valid=1; avg, sum, div_zero stable until out_valid && out_ready -> IDLE next cycle.
//   Latency, n>0: last input handshake at cycle T -> out_valid first high at T+1+ACCW.
//   Latency, n==0: start at cycle T -> out_valid first high at T+1.
//   start outside IDLE is ignored, including start in the same cycle as the output handshake.
//   cfg_num is ignored except in the cycle start is honoured.
//   Outputs are registered; avg/sum/div_zero update only on entry to DONE.
//   div_zero clears on the next honoured start.
// TESTING (DATAW=16, MAX_N=8)
//   num=8, samples 1..8 -> sum=36, avg=4, div_zero=0; out_valid exactly 20 cycles after last sample.
//   num=3, samples -5,0,0 -> sum=-5, avg=-1 (toward zero); samples -7,-1,-1 -> avg=-3.
//   num=0 -> out_valid 1 cycle after start, avg=0, sum=0, div_zero=1; in_ready stays 0.
//   8x 32767 -> sum=262136, avg=32767; 8x -32768 -> sum=-262144, avg=-32768.
//   num=12 -> clamped: 8 samples accepted, 9th stalls (in_ready=0).
//   Random in_valid gaps -> same result; out_ready low 5 cycles -> avg/sum held, start ignored.
//   rst in ACCUM after 3 samples -> next cycle IDLE with all outputs 0; following num=2 batch of 10,20 -> avg=15.

Source files
------------

// File: rtl/batch_avg_unit.sv
// rtl/batch_avg_unit.sv - streaming batch averager: accumulate n signed samples, then restoring-divide by n
module batch_avg_unit #(
    parameter int DATAW  = 16,
    parameter int MAX_N  = 8,
    parameter int COUNTW = $clog2(MAX_N + 1),
    parameter int ACCW   = DATAW + $clog2(MAX_N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [COUNTW-1:0] cfg_num,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATAW-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATAW-1:0]  avg,
    output logic [ACCW-1:0]   sum,
    output logic              div_zero,
    output logic              busy
);
    localparam int CYCW = $clog2(ACCW);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_DIVIDE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            r_state;
    logic [COUNTW-1:0] r_n;
    logic [COUNTW-1:0] r_left;
    logic [ACCW-1:0]   r_acc;
    logic [ACCW-1:0]   r_quot;
    logic [COUNTW-1:0] r_rem;
    logic              r_neg;
    logic [CYCW-1:0]   r_bitcnt;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [DATAW-1:0]  r_avg;
    logic [ACCW-1:0]   r_sum;
    logic              r_div_zero;
    logic              r_busy;

    logic [COUNTW-1:0] w_n_clamp;
    logic [ACCW-1:0]   w_acc_next;
    logic [ACCW-1:0]   w_acc_abs;
    logic [COUNTW:0]   w_trial;
    logic [COUNTW:0]   w_sub;
    logic              w_fits;
    logic [ACCW-1:0]   w_quot_next;
    logic [COUNTW-1:0] w_rem_next;
    logic [DATAW-1:0]  w_q_lo;

    assign w_n_clamp  = (cfg_num > COUNTW'(MAX_N)) ? COUNTW'(MAX_N) : cfg_num;
    assign w_acc_next = r_acc + {{(ACCW-DATAW){in_data[DATAW-1]}}, in_data};
    // Magnitude is read as unsigned, so the most negative sum still divides correctly.
    assign w_acc_abs  = w_acc_next[ACCW-1] ? -w_acc_next : w_acc_next;

    // Remainder stays below n, so one extra bit is enough for the trial subtraction.
    assign w_trial     = {r_rem, r_quot[ACCW-1]};
    assign w_sub       = w_trial - {1'b0, r_n};
    assign w_fits      = ~w_sub[COUNTW];
    assign w_quot_next = {r_quot[ACCW-2:0], w_fits};
    assign w_rem_next  = w_fits ? w_sub[COUNTW-1:0] : w_trial[COUNTW-1:0];
    assign w_q_lo      = w_quot_next[DATAW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_n         <= '0;
            r_left      <= '0;
            r_acc       <= '0;
            r_quot      <= '0;
            r_rem       <= '0;
            r_neg       <= 1'b0;
            r_bitcnt    <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_avg       <= '0;
            r_sum       <= '0;
            r_div_zero  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_n    <= w_n_clamp;
                        r_left <= w_n_clamp;
                        r_acc  <= '0;
                        r_busy <= 1'b1;
                        if (w_n_clamp == '0) begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                            r_avg       <= '0;
                            r_sum       <= '0;
                            r_div_zero  <= 1'b1;
                        end else begin
                            r_state    <= S_ACCUM;
                            r_in_ready <= 1'b1;
                            r_div_zero <= 1'b0;
                        end
                    end
                end
                S_ACCUM: begin
                    if (in_valid && r_in_ready) begin
                        r_acc  <= w_acc_next;
                        r_left <= r_left - COUNTW'(1);
                        if (r_left == COUNTW'(1)) begin
                            r_state    <= S_DIVIDE;
                            r_in_ready <= 1'b0;
                            r_quot     <= w_acc_abs;
                            r_rem      <= '0;
                            r_neg      <= w_acc_next[ACCW-1];
                            r_bitcnt   <= '0;
                        end
                    end
                end
                S_DIVIDE: begin
                    r_quot   <= w_quot_next;
                    r_rem    <= w_rem_next;
                    r_bitcnt <= r_bitcnt + CYCW'(1);
                    if (r_bitcnt == CYCW'(ACCW - 1)) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_sum       <= r_acc;
                        r_avg       <= r_neg ? -w_q_lo : w_q_lo;
                        r_div_zero  <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign avg       = r_avg;
    assign sum       = r_sum;
    assign div_zero  = r_div_zero;
    assign busy      = r_busy;
endmodule

// File: tb/tb_batch_avg_unit.sv
// tb/tb_batch_avg_unit.sv - randomized self-checking bench for batch_avg_unit against an arithmetic model
module tb_batch_avg_unit;
    localparam int DATAW  = 16;
    localparam int MAX_N  = 8;
    localparam int COUNTW = 4;
    localparam int ACCW   = 19;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     start;
    logic [COUNTW-1:0]        cfg_num;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATAW-1:0]  in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATAW-1:0]  avg;
    logic signed [ACCW-1:0]   sum;
    logic                     div_zero;
    logic                     busy;

    int n_checks = 0;
    int n_errors = 0;
    int pcount   = 0;
    int smp[16];

    batch_avg_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_num   (cfg_num),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .avg       (avg),
        .sum       (sum),
        .div_zero  (div_zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) pcount <= pcount + 1;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Model: sum of the first min(cfg,MAX_N) samples, average by truncating integer division.
    task automatic run_batch(input int cfg, input bit gaps, input bit hold);
        int     n;
        int     idx;
        int     guard;
        int     hs_edge;
        bit     hs;
        longint esum;
        longint eavg;
        n = (cfg > MAX_N) ? MAX_N : cfg;
        esum = 0;
        for (int i = 0; i < n; i++) esum += smp[i];
        eavg = (n == 0) ? 0 : esum / n;
        hs_edge = 0;

        @(negedge clk);
        start   = 1'b1;
        cfg_num = COUNTW'(cfg);
        @(negedge clk);
        start   = 1'b0;
        cfg_num = COUNTW'($urandom_range(0, 15));
        if (n == 0) begin
            chk("dz_latency", out_valid, 1);
            chk("dz_in_ready", in_ready, 0);
        end else begin
            idx = 0;
            guard = 0;
            while (idx < n && guard < 500) begin
                in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                in_data  = DATAW'(smp[idx]);
                hs = in_valid && in_ready;
                @(negedge clk);
                if (hs) begin
                    idx++;
                    hs_edge = pcount;
                end
                guard++;
            end
            chk("accept_count", idx, n);
            in_valid = (cfg > MAX_N);
            in_data  = 16'sh7fff;
            guard = 0;
            while (!out_valid && guard < 100) begin
                if (cfg > MAX_N && guard == 0) chk("clamp_stall", in_ready, 0);
                @(negedge clk);
                guard++;
            end
            in_valid = 1'b0;
            chk("latency", pcount - hs_edge, ACCW);
        end
        chk("out_valid", out_valid, 1);
        chk("avg", avg, eavg);
        chk("sum", sum, esum);
        chk("div_zero", div_zero, (n == 0));
        chk("busy_done", busy, 1);
        if (hold) begin
            start   = 1'b1;
            cfg_num = 4'd3;
            repeat (5) @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_avg", avg, eavg);
            chk("hold_sum", sum, esum);
            out_ready = 1'b1;
            @(negedge clk);
            chk("accept_clears", out_valid, 0);
            chk("busy_idle", busy, 0);
            start     = 1'b0;
            out_ready = 1'b0;
            @(negedge clk);
            chk("start_ignored", busy, 0);
        end else begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            chk("accept_clears", out_valid, 0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        cfg_num   = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_avg", avg, 0);
        chk("rst_sum", sum, 0);
        chk("rst_div_zero", div_zero, 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) smp[i] = i + 1;
        run_batch(8, 1'b0, 1'b0);
        smp[0] = -5; smp[1] = 0; smp[2] = 0;
        run_batch(3, 1'b0, 1'b0);
        smp[0] = -7; smp[1] = -1; smp[2] = -1;
        run_batch(3, 1'b0, 1'b1);
        run_batch(0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) smp[i] = 32767;
        run_batch(8, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) smp[i] = -32768;
        run_batch(8, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) smp[i] = $urandom_range(0, 65535) - 32768;
        run_batch(12, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) smp[i] = i + 1;
        run_batch(8, 1'b1, 1'b1);

        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < 16; i++) smp[i] = $urandom_range(0, 65535) - 32768;
            run_batch($urandom_range(0, 15), 1'($urandom_range(0, 1)), 1'b0);
        end

        smp[0] = 100; smp[1] = 200; smp[2] = 300;
        @(negedge clk);
        start   = 1'b1;
        cfg_num = 4'd5;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = DATAW'(smp[k]);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_avg", avg, 0);
        chk("mid_rst_sum", sum, 0);
        chk("mid_rst_div_zero", div_zero, 0);
        smp[0] = 10; smp[1] = 20;
        run_batch(2, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
